// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its skid buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register {valid, instr, pcplus4} catching a word fetched while IF/ID is stalled.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pcplus4,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pcplus4
);

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = INSTR_NOP;
        end else if (load) begin
            valid_d   = 1'b1;
            instr_d   = load_instr;
            pcplus4_d = load_pcplus4;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= INSTR_NOP;
            pcplus4_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign valid   = valid_q;
    assign instr   = instr_q;
    assign pcplus4 = pcplus4_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem handshake, IF/ID register plus skid, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating FetchCnt/StallCnt outputs.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    input  logic [31:0]       IMemData,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic [31:0]       Instr,
    output logic [5:0]        Opcode,
    output logic [5:0]        Func,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              InstrValid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       FetchCnt,
    output logic [31:0]       StallCnt
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;
    // Keeps IMemReq low while reset is asserted and for the first cycle after release.
    logic              active_q;

    logic              skid_load, skid_unload, skid_flush;
    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pcplus4;

    logic              imem_req;
    logic              ack_hit;
    logic              consume;
    logic              ifid_free;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] redirect_target;

    fetch_skid_buf #(.ADDR_W(ADDR_W)) u_skid (
        .clk          (Clk),
        .rst_n        (Rst_n),
        .load         (skid_load),
        .unload       (skid_unload),
        .flush        (skid_flush),
        .load_instr   (IMemData),
        .load_pcplus4 (pc_next),
        .valid        (skid_valid),
        .instr        (skid_instr),
        .pcplus4      (skid_pcplus4)
    );

    assign imem_req        = active_q &&
                             ((state_q == DISCARD) || ((state_q == FETCH) && !skid_valid));
    assign ack_hit         = imem_req && IMemAck;
    assign consume         = valid_q && !Stall;
    assign ifid_free       = !valid_q || !Stall;
    assign pc_next         = pc_q + ADDR_W'(PC_INCR);
    assign redirect_target = RedirectPC & ALIGN_MASK;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_pc_d  = redir_pc_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        pcplus4_d   = pcplus4_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;

        if (Redirect) begin
            valid_d    = 1'b0;
            instr_d    = INSTR_NOP;
            pcplus4_d  = '0;
            skid_flush = 1'b1;
            // The address must not move while a request is outstanding and unacked.
            if (imem_req && !IMemAck) begin
                state_d    = DISCARD;
                redir_pc_d = redirect_target;
            end else begin
                state_d = FETCH;
                pc_d    = redirect_target;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack_hit) begin
                        pc_d = pc_next;
                        if (ifid_free) begin
                            valid_d   = 1'b1;
                            instr_d   = IMemData;
                            pcplus4_d = pc_next;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end else if (consume) begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        valid_d     = 1'b1;
                        instr_d     = skid_instr;
                        pcplus4_d   = skid_pcplus4;
                        skid_unload = 1'b1;
                        state_d     = FETCH;
                    end
                end
                DISCARD: begin
                    if (consume) begin
                        valid_d = 1'b0;
                    end
                    if (ack_hit) begin
                        pc_d    = redir_pc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            redir_pc_q <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= INSTR_NOP;
            pcplus4_q  <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_pc_q <= redir_pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pcplus4_q  <= pcplus4_d;
            active_q   <= 1'b1;
        end
    end

    assign IMemReq    = imem_req;
    assign IMemAddr   = pc_q;
    assign Instr      = instr_q;
    assign InstrValid = valid_q;
    assign PCPlus4    = pcplus4_q;
    // An empty IF/ID presents opcode/func 0: a shift of r0, i.e. a bubble.
    assign Opcode     = valid_q ? instr_q[OPCODE_MSB:OPCODE_LSB] : 6'd0;
    assign Func       = valid_q ? instr_q[FUNC_MSB:FUNC_LSB] : 6'd0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Instructions flushed by a redirect are neither counted as fetched nor as stalled.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (consume && !Redirect && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (valid_q && Stall && !Redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FetchCnt = fetch_cnt_q;
    assign StallCnt = stall_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed self-checking bench for instr_fetch_stage with hand-computed expectations.
`timescale 1ns/1ps
module tb_instr_fetch_stage;

    logic        Clk;
    logic        Rst_n;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [5:0]  Func;
    logic [31:0] PCPlus4;
    logic        InstrValid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCnt;
    logic [31:0] StallCnt;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Instr      (Instr),
        .Opcode     (Opcode),
        .Func       (Func),
        .PCPlus4    (PCPlus4),
        .InstrValid (InstrValid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCnt   (FetchCnt),
        .StallCnt   (StallCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Rst_n = 1'b0; IMemAck = 1'b0; IMemData = '0; Stall = 1'b0;
        Redirect = 1'b0; RedirectPC = '0;
        step(); step();
        Rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; IMemAck = 1'b0; IMemData = '0; Stall = 1'b0;
        Redirect = 1'b0; RedirectPC = '0;
        step(); step();
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", IMemReq); end
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", InstrValid); end
        checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", Instr); end
        checks++; if ({Opcode, Func} !== 12'h0) begin errors++; $display("FAIL reset_opfunc: got %h/%h expected 0/0", Opcode, Func); end
        checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcplus4: got %h expected 0", PCPlus4); end
        Rst_n = 1'b1;
        step();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", IMemReq, IMemAddr); end
        // Asynchronous reset in the middle of a pending request.
        Rst_n = 1'b0;
        #1;
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL reset_async_drop: got req=%b expected 0", IMemReq); end
        step();
        Rst_n = 1'b1;
        step();
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL reset_rerelease: got req=%b addr=%h expected req=1 addr=0", IMemReq, IMemAddr); end
    endtask

    task automatic test_back_to_back();
        IMemAck = 1'b1; IMemData = 32'h0000_0020;
        step();
        checks++; if (InstrValid !== 1'b1 || Instr !== 32'h0000_0020) begin errors++; $display("FAIL b2b_word0: got v=%b instr=%h expected v=1 instr=00000020", InstrValid, Instr); end
        checks++; if (Opcode !== 6'h00 || Func !== 6'h20) begin errors++; $display("FAIL b2b_opfunc0: got %h/%h expected 00/20", Opcode, Func); end
        checks++; if (PCPlus4 !== 32'h4 || IMemAddr !== 32'h4) begin errors++; $display("FAIL b2b_pc0: got pcplus4=%h addr=%h expected 4/4", PCPlus4, IMemAddr); end
        IMemData = 32'h0000_0022;
        step();
        checks++; if (Opcode !== 6'h00 || Func !== 6'h22) begin errors++; $display("FAIL b2b_opfunc1: got %h/%h expected 00/22", Opcode, Func); end
        checks++; if (PCPlus4 !== 32'h8 || IMemAddr !== 32'h8) begin errors++; $display("FAIL b2b_pc1: got pcplus4=%h addr=%h expected 8/8", PCPlus4, IMemAddr); end
        IMemAck = 1'b0;
        step();
        checks++; if (InstrValid !== 1'b0 || Func !== 6'h00) begin errors++; $display("FAIL b2b_drain: got v=%b func=%h expected v=0 func=00", InstrValid, Func); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h8) begin errors++; $display("FAIL b2b_next_req: got req=%b addr=%h expected 1/8", IMemReq, IMemAddr); end
    endtask

    task automatic test_stall_skid();
        IMemAck = 1'b1; IMemData = 32'h8C01_0004;
        step();
        checks++; if (Opcode !== 6'h23 || Func !== 6'h04) begin errors++; $display("FAIL stall_first: got %h/%h expected 23/04", Opcode, Func); end
        Stall = 1'b1; IMemData = 32'h0000_002A;
        step();
        checks++; if (Instr !== 32'h8C01_0004 || IMemReq !== 1'b0) begin errors++; $display("FAIL stall_hold: got instr=%h req=%b expected 8c010004/0", Instr, IMemReq); end
        checks++; if (IMemAddr !== 32'h10) begin errors++; $display("FAIL stall_pc: got %h expected 00000010", IMemAddr); end
        IMemAck = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (InstrValid !== 1'b1 || Instr !== 32'h8C01_0004 || IMemReq !== 1'b0) begin errors++; $display("FAIL stall_wait%0d: got v=%b instr=%h req=%b expected 1/8c010004/0", i, InstrValid, Instr, IMemReq); end
        end
        Stall = 1'b0;
        step();
        checks++; if (InstrValid !== 1'b1 || Instr !== 32'h0000_002A || PCPlus4 !== 32'h10) begin errors++; $display("FAIL stall_release: got v=%b instr=%h pcplus4=%h expected 1/0000002a/10", InstrValid, Instr, PCPlus4); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h10) begin errors++; $display("FAIL stall_resume: got req=%b addr=%h expected 1/10", IMemReq, IMemAddr); end
        step();
        checks++; if (InstrValid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got v=%b expected 0", InstrValid); end
    endtask

    task automatic test_redirect_pending();
        Redirect = 1'b1; RedirectPC = 32'h0000_0500;
        step();
        checks++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h10) begin errors++; $display("FAIL discard_enter: got v=%b req=%b addr=%h expected 0/1/10", InstrValid, IMemReq, IMemAddr); end
        RedirectPC = 32'h0000_0103;
        step();
        checks++; if (InstrValid !== 1'b0 || IMemAddr !== 32'h10) begin errors++; $display("FAIL discard_wait: got v=%b addr=%h expected 0/10", InstrValid, IMemAddr); end
        Redirect = 1'b0; IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;
        step();
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h0) begin errors++; $display("FAIL discard_drop: got v=%b instr=%h expected 0/0", InstrValid, Instr); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h100) begin errors++; $display("FAIL discard_target: got req=%b addr=%h expected 1/100", IMemReq, IMemAddr); end
        IMemAck = 1'b0;
    endtask

    task automatic test_redirect_ack();
        IMemAck = 1'b1; IMemData = 32'h1234_5678; Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        step();
        checks++; if (InstrValid !== 1'b0 || Instr !== 32'h0 || IMemAddr !== 32'h200) begin errors++; $display("FAIL redir_ack: got v=%b instr=%h addr=%h expected 0/0/200", InstrValid, Instr, IMemAddr); end
        Redirect = 1'b0; IMemData = 32'h0000_0008;
        step();
        checks++; if (InstrValid !== 1'b1 || PCPlus4 !== 32'h204) begin errors++; $display("FAIL redir_refetch: got v=%b pcplus4=%h expected 1/204", InstrValid, PCPlus4); end
        // Redirect beats Stall: the acked word must not land in the skid.
        Stall = 1'b1; Redirect = 1'b1; RedirectPC = 32'h0000_0300; IMemData = 32'h0000_0011;
        step();
        checks++; if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 32'h300) begin errors++; $display("FAIL redir_over_stall: got v=%b req=%b addr=%h expected 0/1/300", InstrValid, IMemReq, IMemAddr); end
        Stall = 1'b0; Redirect = 1'b0; IMemAck = 1'b0;
    endtask

    task automatic test_pc_wrap();
        IMemAck = 1'b1; Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        step();
        checks++; if (IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h expected fffffffc", IMemAddr); end
        Redirect = 1'b0; IMemData = 32'h0000_0025;
        step();
        checks++; if (InstrValid !== 1'b1 || Instr !== 32'h0000_0025 || PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4: got v=%b instr=%h pcplus4=%h expected 1/00000025/0", InstrValid, Instr, PCPlus4); end
        checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", IMemAddr); end
        IMemAck = 1'b0;
        step();
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_counters();
        apply_reset();
        checks++; if (FetchCnt !== 32'd0 || StallCnt !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", FetchCnt, StallCnt); end
        IMemAck = 1'b1; IMemData = 32'h0000_0020; step();
        IMemData = 32'h0000_0021; step();
        IMemAck = 1'b0; Stall = 1'b1; step(); step();
        Stall = 1'b0; step();
        IMemAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IMemData = 32'h0000_0030 + i;
            step();
        end
        Redirect = 1'b1; RedirectPC = 32'h0000_0400; step();
        Redirect = 1'b0; IMemAck = 1'b0; step();
        checks++; if (FetchCnt !== 32'd5) begin errors++; $display("FAIL perf_fetch: got %0d expected 5", FetchCnt); end
        checks++; if (StallCnt !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d expected 2", StallCnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_stall_skid();
        test_redirect_pending();
        test_redirect_ack();
        test_pc_wrap();
`ifdef FETCH_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
